// File: rtl/cpu_alu_pkg.sv
// Shared core ALU control codes; every block that drives the ALU imports these.
package cpu_alu_pkg;
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b1000;
endpackage

// File: rtl/cpu_div_pkg.sv
// Encodings for the multi-cycle RV32M divide sequencer (op field and FSM states).
package cpu_div_pkg;
    localparam int XLEN = 32;

    // funct3[1:0] of DIV/DIVU/REM/REMU
    localparam logic [1:0] DIV_OP_DIV  = 2'b00;
    localparam logic [1:0] DIV_OP_DIVU = 2'b01;
    localparam logic [1:0] DIV_OP_REM  = 2'b10;
    localparam logic [1:0] DIV_OP_REMU = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_NEG_A = 3'd1,
        S_NEG_B = 3'd2,
        S_ITER  = 3'd3,
        S_NEG_Q = 3'd4,
        S_NEG_R = 3'd5,
        S_DONE  = 3'd6
    } div_state_e;
endpackage

// File: rtl/cpu_div_seq.sv
// Restoring divider for DIV/DIVU/REM/REMU that borrows the shared core ALU for
// every subtraction (operand negation and one quotient bit per cycle).
module cpu_div_seq
    import cpu_alu_pkg::*;
    import cpu_div_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        kill,
    output logic        ready,
    output logic        done,
    output logic [31:0] result,
    output logic        alu_req,
    output logic [31:0] alu_src_a,
    output logic [31:0] alu_src_b,
    output logic [3:0]  alu_control,
    input  logic [31:0] alu_result,
    input  logic        alu_borrow
);
    div_state_e  state, state_nxt;
    logic [1:0]  op_r;
    logic [31:0] q, rem, b;
    logic [4:0]  cnt;
    logic        sign_q, sign_r;
    logic [31:0] shifted;
    logic        take;
    logic        in_signed;

    assign in_signed = ~op[0];

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        ready       = 1'b0;
        done        = 1'b0;
        result      = '0;
        alu_req     = 1'b0;
        alu_src_a   = '0;
        alu_src_b   = '0;
        alu_control = ALU_ADD;
        shifted     = {rem[30:0], q[31]};
        // rem[31] set means the true partial remainder is >= 2^32 > b, so the
        // subtraction always succeeds and the wrapped 32-bit difference is exact.
        take        = ~alu_borrow | rem[31];
        case (state)
            S_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    if (divisor == '0)                      state_nxt = S_DONE;
                    else if (in_signed && dividend[31])    state_nxt = S_NEG_A;
                    else if (in_signed && divisor[31])     state_nxt = S_NEG_B;
                    else                                   state_nxt = S_ITER;
                end
            end
            S_NEG_A: begin
                alu_req     = 1'b1;
                alu_src_b   = q;
                alu_control = ALU_SUB;
                state_nxt   = (~op_r[0] && b[31]) ? S_NEG_B : S_ITER;
            end
            S_NEG_B: begin
                alu_req     = 1'b1;
                alu_src_b   = b;
                alu_control = ALU_SUB;
                state_nxt   = S_ITER;
            end
            S_ITER: begin
                alu_req     = 1'b1;
                alu_src_a   = shifted;
                alu_src_b   = b;
                alu_control = ALU_SUB;
                if (cnt == 5'd31) begin
                    if (op_r == DIV_OP_DIV && sign_q)      state_nxt = S_NEG_Q;
                    else if (op_r == DIV_OP_REM && sign_r) state_nxt = S_NEG_R;
                    else                                   state_nxt = S_DONE;
                end
            end
            S_NEG_Q: begin
                alu_req     = 1'b1;
                alu_src_b   = q;
                alu_control = ALU_SUB;
                state_nxt   = S_DONE;
            end
            S_NEG_R: begin
                alu_req     = 1'b1;
                alu_src_b   = rem;
                alu_control = ALU_SUB;
                state_nxt   = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                result    = op_r[1] ? rem : q;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (kill) state_nxt = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_r   <= '0;
            q      <= '0;
            rem    <= '0;
            b      <= '0;
            cnt    <= '0;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    op_r   <= op;
                    b      <= divisor;
                    cnt    <= '0;
                    sign_q <= in_signed & (dividend[31] ^ divisor[31]);
                    sign_r <= in_signed & dividend[31];
                    // Divide-by-zero skips iteration; preload the architected results.
                    if (divisor == '0) begin
                        q   <= '1;
                        rem <= dividend;
                    end else begin
                        q   <= dividend;
                        rem <= '0;
                    end
                end
                S_NEG_A: q <= alu_result;
                S_NEG_B: b <= alu_result;
                S_ITER: begin
                    rem <= take ? alu_result : shifted;
                    q   <= {q[30:0], take};
                    cnt <= cnt + 5'd1;
                end
                S_NEG_Q: q   <= alu_result;
                S_NEG_R: rem <= alu_result;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_div_seq.sv
// Bench for cpu_div_seq: directed cases plus randomized operations against an
// arithmetic reference model; a combinational ALU model stands in for the core ALU.
module tb_cpu_div_seq;
    import cpu_alu_pkg::*;
    import cpu_div_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        kill = 1'b0;
    logic        ready, done, alu_req;
    logic [31:0] result, alu_src_a, alu_src_b, alu_result;
    logic [3:0]  alu_control;
    logic        alu_borrow;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    cpu_div_seq dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .dividend(dividend), .divisor(divisor), .kill(kill),
        .ready(ready), .done(done), .result(result),
        .alu_req(alu_req), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_control(alu_control), .alu_result(alu_result), .alu_borrow(alu_borrow)
    );

    always #5 clk = ~clk;

    // Core ALU: only SUB is exercised by the divider.
    assign alu_result = (alu_control == ALU_SUB) ? alu_src_a - alu_src_b : alu_src_a + alu_src_b;
    assign alu_borrow = (alu_control == ALU_SUB) && (alu_src_a < alu_src_b);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [1:0] o, input logic [31:0] a, input logic [31:0] d);
        int sa, sd;
        sa = a;
        sd = d;
        if (d == 0) return o[1] ? a : 32'hFFFF_FFFF;
        case (o)
            DIV_OP_DIVU: return a / d;
            DIV_OP_REMU: return a % d;
            DIV_OP_DIV:  return (a == 32'h8000_0000 && d == 32'hFFFF_FFFF) ? a : 32'(sa / sd);
            default:     return (a == 32'h8000_0000 && d == 32'hFFFF_FFFF) ? 32'h0 : 32'(sa % sd);
        endcase
    endfunction

    function automatic int ref_latency(input logic [1:0] o, input logic [31:0] a, input logic [31:0] d);
        bit sgn;
        int lat;
        sgn = (o == DIV_OP_DIV) || (o == DIV_OP_REM);
        if (d == 0) return 1;
        lat = 33;
        if (sgn && a[31]) lat++;
        if (sgn && d[31]) lat++;
        if ((o == DIV_OP_DIV && (a[31] ^ d[31])) || (o == DIV_OP_REM && a[31])) lat++;
        return lat;
    endfunction

    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] er, input int el);
        int cyc, req_cyc;
        bit bus_ok;
        @(negedge clk);
        check("ready_idle", 32'(ready), 32'd1);
        start = 1'b1; op = o; dividend = a; divisor = d;
        exp_q.push_back(er);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; dividend = $urandom; divisor = $urandom; op = 2'($urandom_range(0, 3));
        cyc = 1; req_cyc = 0; bus_ok = 1'b1;
        while (!done && cyc < 100) begin
            if (alu_req) begin
                req_cyc++;
                if (alu_control !== ALU_SUB) bus_ok = 1'b0;
            end else if (alu_control !== ALU_ADD || alu_src_a !== 0 || alu_src_b !== 0) begin
                bus_ok = 1'b0;
            end
            if (ready || result !== 0) bus_ok = 1'b0;
            @(negedge clk);
            cyc++;
        end
        check("done_seen", 32'(done), 32'd1);
        check("latency", 32'(cyc), 32'(el));
        check("result", result, exp_q.pop_front());
        check("alu_req_in_done", 32'(alu_req), 32'd0);
        check("alu_req_cycles", 32'(req_cyc), 32'(el - 1));
        check("alu_bus", 32'(bus_ok), 32'd1);
        @(negedge clk);
        check("ready_after", 32'(ready), 32'd1);
        check("done_after", 32'(done), 32'd0);
    endtask

    // Start a long DIVU, then abort it in the 10th ITER cycle with kill or rst.
    task automatic abort_op(input bit use_rst);
        @(negedge clk);
        start = 1'b1; op = DIV_OP_DIVU; dividend = 32'hDEAD_BEEF; divisor = 32'd3;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("busy_before_abort", 32'(alu_req), 32'd1);
        if (use_rst) rst = 1'b1; else kill = 1'b1;
        @(negedge clk);
        rst = 1'b0; kill = 1'b0;
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_alu_req", 32'(alu_req), 32'd0);
        check("abort_done", 32'(done), 32'd0);
    endtask

    function automatic logic [31:0] pick_operand(input bit allow_zero);
        logic [31:0] specials [5];
        specials = '{32'h0000_0001, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0001};
        case ($urandom_range(0, 3))
            0: return $urandom;
            1: return 32'($signed($urandom_range(0, 40)) - 20);
            2: return specials[$urandom_range(0, 4)];
            default: return allow_zero ? 32'h0 : 32'($urandom_range(1, 1000));
        endcase
    endfunction

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra, rd;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", result, 32'h0);
        check("rst_alu_req", 32'(alu_req), 32'd0);
        check("rst_src_a", alu_src_a, 32'h0);
        check("rst_src_b", alu_src_b, 32'h0);
        check("rst_control", 32'(alu_control), 32'(ALU_ADD));
        rst = 1'b0;

        run_op(DIV_OP_DIVU, 32'd100, 32'd7, 32'd14, 33);
        run_op(DIV_OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 35);
        run_op(DIV_OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 35);
        run_op(DIV_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 35);
        run_op(DIV_OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 36);
        run_op(DIV_OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        run_op(DIV_OP_REMU, 32'd5, 32'd0, 32'd5, 1);
        run_op(DIV_OP_REMU, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 33);
        run_op(DIV_OP_DIVU, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 33);

        abort_op(1'b0);
        run_op(DIV_OP_DIVU, 32'd9, 32'd3, 32'd3, 33);
        abort_op(1'b1);
        run_op(DIV_OP_DIVU, 32'd9, 32'd3, 32'd3, 33);

        // kill in the same cycle as start drops the request
        @(negedge clk);
        start = 1'b1; kill = 1'b1; op = DIV_OP_DIVU; dividend = 32'd50; divisor = 32'd5;
        @(negedge clk);
        start = 1'b0; kill = 1'b0;
        check("kill_start_ready", 32'(ready), 32'd1);
        check("kill_start_alu_req", 32'(alu_req), 32'd0);
        @(negedge clk);
        check("kill_start_done", 32'(done), 32'd0);

        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = pick_operand(1'b1);
            rd = pick_operand(($urandom_range(0, 7) == 0));
            run_op(ro, ra, rd, ref_result(ro, ra, rd), ref_latency(ro, ra, rd));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cpu_div_seq.md
Name: cpu_div_seq

Overview:
Multi-cycle sequencer for RV32M DIV/DIVU/REM/REMU that runs restoring division on the shared 32-bit core ALU instead of a dedicated subtractor.
- Drives the ALU operand/control inputs one subtraction per cycle and consumes its result and borrow.
- Sits beside the execute stage; the pipeline stalls on !ready and muxes ALU inputs to this block while alu_req=1.

Parameters:
XLEN, 32, datapath width; only 32 is supported. The iteration counter width is log2(XLEN)=5.

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
start  in  1  request; accepted only when ready=1
op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU (funct3[1:0]); sampled on accept
dividend  in  32  sampled on accept
divisor  in  32  sampled on accept
kill  in  1  synchronous abort (pipeline flush)
ready  out  1  idle, can accept start
done  out  1  one-cycle pulse; result valid this cycle only
result  out  32  quotient or remainder
alu_req  out  1  block owns the ALU this cycle
alu_src_a  out  32  ALU operand A
alu_src_b  out  32  ALU operand B
alu_control  out  4  ALU op code (ALU_SUB while alu_req=1)
alu_result  in  32  ALU result, same cycle (combinational)
alu_borrow  in  1  ALU borrow, same cycle

Behaviour:
- Reset values: state=IDLE, ready=1, done=0, result=0, alu_req=0, alu_src_a=0, alu_src_b=0, alu_control=ALU_ADD. These same values apply whenever alu_req=0.
- States: IDLE, NEG_A, NEG_B, ITER, NEG_Q, NEG_R, DONE. ready=1 only in IDLE.
- Accept (IDLE, start=1):
  - Latch op, a=dividend, b=divisor, q=a, rem=0, cnt=0.
  - sign_q = signed op & (a[31]^b[31]); sign_r = signed op & a[31].
- Next state after accept:
  - b==0 -> DONE. Result = 0xFFFFFFFF for DIV/DIVU; original dividend for REM/REMU.
  - Else, signed op with a[31]=1 -> NEG_A.
  - Else, signed op with b[31]=1 -> NEG_B.
  - Else -> ITER.
- Negation states: ALU src_a=0, src_b=x, SUB; register alu_result back into x.
  - NEG_A negates q and then goes to NEG_B if b[31]=1, else ITER.
  - NEG_B negates b, then goes to ITER.
- ITER, one step per cycle, exactly 32 cycles:
  - s = {rem[30:0], q[31]}; src_a=s, src_b=b, SUB.
  - take = !alu_borrow | rem[31]. rem[31] means the true 33-bit partial remainder is at least 2^32 > b, so the 32-bit wrapped result is correct.
  - rem <= take ? alu_result : s; q <= {q[30:0], take}; cnt++.
  - At cnt=31 go to NEG_Q if (op DIV & sign_q), NEG_R if (op REM & sign_r), else DONE.
- NEG_Q / NEG_R negate q / rem via the ALU, then go to DONE.
- DONE: done=1, result = q (DIV/DIVU) or rem (REM/REMU), next state IDLE. Back-to-back start is accepted in the following cycle.
- Overflow case -2^31 / -1: handled by the normal path. |a|=0x80000000, q=0x80000000, no negation (signs equal), rem=0.
- Latency from accept edge to done cycle:
  - divide-by-zero: 1 cycle
  - unsigned: 33 cycles
  - signed: 33 + up to 2 input negations + 1 output negation
- kill=1 in any state: next state IDLE, no done pulse, alu_req=0 next cycle. kill has priority over start in the same cycle, so that start is dropped.
- rst has priority over kill and everything else.
- start while ready=0 is ignored. The requester must hold start until it sees ready.

Decomposition:
- The shared ALU control-code header already provides ALU_SUB and ALU_ADD. Reuse it; define no local copies.
- New shared header cpu_div.vh holds:
  - op encodings DIV_OP_DIV/DIVU/REM/REMU
  - state encodings (3-bit)
- No sub-module: the ALU is external and shared. The block is one FSM with q/rem/b/cnt registers and an ALU-drive mux.

Test Plan:
- DIVU 100/7, accept at cycle 0 -> alu_req=1 cycles 1-32; done at cycle 33 with result=14; ready=1 at cycle 34.
- REM -7 (0xFFFFFFF9) % 2 -> NEG_A, 32 ITER, NEG_R; done at cycle 35 with result 0xFFFFFFFF. DIV -7/2 gives the same latency with result 0xFFFFFFFD.
- DIV 0x80000000 / 0xFFFFFFFF -> result 0x80000000. REM with the same operands -> 0.
- DIV 5/0 -> done at cycle 1, result 0xFFFFFFFF, alu_req stays 0. REMU 5/0 -> result 5.
- REMU 0xFFFFFFFF % 0x80000001 -> 0x7FFFFFFE. DIVU with the same operands -> 1 (exercises the rem[31] take path).
- DIVU started, kill asserted in the 10th ITER cycle -> no done pulse, ready=1 and alu_req=0 next cycle. A new DIVU 9/3 accepted immediately after -> result 3. Repeat with rst instead of kill and expect the same response.
